pwm_multi_gen: RTL and testbench
================================

# pwm_multi_gen

Multi-channel PWM generator with per-channel duty control from active-low pushbuttons. It is the parametrised successor to the single-channel 8-bit PWM block, adding channel count, width, period and step parameters, synchronised and debounced button inputs, saturating duty arithmetic, and glitch-free duty updates at period boundaries. It sits between board pushbuttons/GPIO and the PWM output pins. A shared period counter is exported for LED/debug displays.

## Interface
- `CH`, 4, number of PWM channels (1..16)
- `CW`, 8, counter/duty width in bits
- `PERIOD`, 50, counter modulus in clocks; 2 ≤ PERIOD ≤ 2^CW − 1
- `STEP`, 5, duty increment/decrement per button press; 1 ≤ STEP ≤ PERIOD
- `DB_CYCLES`, 4, required stable clocks for debounce; ≥ 1

- `clk` input 1: system clock; all logic on rising edge
- `reset` input 1: asynchronous, active-low
- `inc_n` input CH: per-channel increment button, active-low, asynchronous
- `dec_n` input CH: per-channel decrement button, active-low, asynchronous
- `pwm` output CH: PWM outputs
- `cnt` output CW: shared period counter
- `wrap` output 1: one-clock pulse, high in the first cycle of each period (cnt==0, counting up)
- `duty_dbg` output CH*CW: active duty values, channel 0 in LSBs

## Operation
- **Reset (reset=0).** cnt=0, direction=up, all shadow and active duties=0, pwm=0, wrap=0. Synchroniser flops and debounced states are set to 1 (released). Debounce counters are cleared.
- **Synchroniser.** Each inc_n/dec_n bit passes through a 2-flop synchroniser.
- **Debounce.** Each of the 2·CH inputs has its own counter.
  - The counter increments while the synced value differs from the stable state.
  - It clears when they are equal.
  - On reaching DB_CYCLES, the stable state takes the synced value and the counter clears.
- **Press detection.** A 1→0 transition of a stable state produces a one-clock press pulse.
- **Duty arithmetic.** The shadow duty is CW bits, range 0..PERIOD, and saturates at both ends.
  - inc: shadow = min(shadow+STEP, PERIOD).
  - dec: shadow = max(shadow−STEP, 0), computed without underflow.
  - inc and dec pulses on the same channel in the same clock: no change.
- **Duty update.** Active duty loads from shadow on the clock edge where cnt becomes 0 with direction up. It is applied from the first cycle of the new period.
- **Output.** pwm[i] = (cnt < active_duty[i]), registered.
  - Duty 0 gives constant low.
  - Duty PERIOD gives constant high with no glitch.
- **Counter, edge-aligned mode.** cnt counts 0,1,…,PERIOD−1, 0, …; period = PERIOD clocks.

## Timing
- Shadow duty changes on the (DB_CYCLES+3)th rising edge after a held button falls: 2 synchroniser edges, DB_CYCLES debounce edges, 1 arithmetic edge.
- Button releases are also debounced but produce no step.
- Bounces shorter than DB_CYCLES clocks produce no step.
- A shadow change anywhere in a period takes effect at the next period start. A shadow change on the same edge as the load takes effect one period later.
- pwm and wrap are registered and track cnt with 0 cycles of skew.
  - pwm is high for exactly active_duty cycles per edge-aligned period.
- Asserting reset mid-period forces all outputs low immediately.
  - After reset release, the first rising edge counts to cnt=1.

## Configuration
- `PWM_CENTER_ALIGN_EN` defined: cnt counts up 0…PERIOD−1, then down PERIOD−2…1, then repeats.
  - Period = 2·PERIOD−2 clocks.
  - pwm[i] is high for 2·active_duty−1 cycles, symmetric about cnt=PERIOD−1, when 0<duty<PERIOD.
  - Duty 0 gives constant low; duty PERIOD gives constant high.
  - wrap and duty load occur only at cnt=0.
- `PWM_CENTER_ALIGN_EN` undefined: edge-aligned only; no direction register is synthesised.

## Test plan
Bench defaults: CH=4, CW=8, PERIOD=50, STEP=5, DB_CYCLES=4.
- **Reset defaults.** Hold reset low, then release → pwm=0, cnt runs 0..49, wrap pulses every 50 clocks, duty_dbg=0.
- **Single press.** Hold inc_n[1] low for 10 clocks → shadow[1]=5 at edge 7. From the next wrap, pwm[1] is high exactly 5 of 50 clocks; other channels stay low.
- **Saturation.** 12 presses on inc_n[0] → duty saturates at 50 and pwm[0] is constantly high. Then 11 presses on dec_n[0] → duty=0 (no underflow), pwm[0] constantly low.
- **Debounce.** Toggle inc_n[2] with low pulses of 3 clocks → no change. Hold for 4+ clocks → exactly one step.
- **Simultaneous events.** Press inc_n[3] and dec_n[3] together → no change. Change shadow mid-period → pwm width is unchanged until the next wrap. Assert reset mid-period → pwm=0 and cnt=0 immediately.
- **Center-aligned (PWM_CENTER_ALIGN_EN).** Set duty=10 → period 98 clocks; pwm high for 19 clocks centred on cnt=49.

Source files
------------

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen
//
// Multi-channel PWM generator. Each channel's duty is stepped up or down by
// active-low pushbuttons. Buttons are synchronised and debounced, duty
// arithmetic saturates at 0 and PERIOD, and the active duty used for the
// comparison is only reloaded at a period start, so a duty change never
// produces a glitch mid-period.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous reset, active-low
//   inc_n     per-channel increment buttons, active-low, asynchronous
//   dec_n     per-channel decrement buttons, active-low, asynchronous
//   pwm       registered PWM outputs
//   cnt       shared period counter
//   wrap      one-clock pulse in the first cycle of each period (cnt==0)
//   duty_dbg  active duty values, channel 0 in the LSBs
//
// Build option:
//   PWM_CENTER_ALIGN_EN  when defined, the counter runs up then down
//                        (center-aligned PWM); otherwise edge-aligned only.

module pwm_multi_gen #(
  parameter int CH        = 4,
  parameter int CW        = 8,
  parameter int PERIOD    = 50,
  parameter int STEP      = 5,
  parameter int DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH-1:0]    inc_n,
  input  logic [CH-1:0]    dec_n,
  output logic [CH-1:0]    pwm,
  output logic [CW-1:0]    cnt,
  output logic             wrap,
  output logic [CH*CW-1:0] duty_dbg
);

  localparam int NB  = 2 * CH;
  localparam int DBW = $clog2(DB_CYCLES + 1);

  localparam logic [CW-1:0]  P_VAL   = CW'(PERIOD);
  localparam logic [CW-1:0]  P_LAST  = CW'(PERIOD - 1);
  localparam logic [CW-1:0]  STEP_V  = CW'(STEP);
  localparam logic [CW-1:0]  INC_LIM = CW'(PERIOD - STEP);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  // Buttons are handled as one vector: increments in the low half,
  // decrements in the high half.
  logic [NB-1:0]          btn_raw;
  logic [NB-1:0]          sync1;
  logic [NB-1:0]          sync2;
  logic [NB-1:0]          stable;
  logic [NB-1:0]          press;
  logic [NB-1:0][DBW-1:0] db_cnt;

  logic [CH-1:0][CW-1:0]  shadow;
  logic [CH-1:0][CW-1:0]  active;
  logic [CH-1:0][CW-1:0]  active_next;
  logic [CH-1:0]          pwm_next;
  logic [CW-1:0]          cnt_next;
  logic                   load;

  assign btn_raw  = {dec_n, inc_n};
  assign duty_dbg = active;

  // Two-flop synchroniser; resets to the released (high) level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Per-input debounce. The counter runs while the synced level differs
  // from the stable level; after DB_CYCLES consecutive differing clocks the
  // stable level follows. A falling stable level raises a one-clock press
  // pulse that the duty arithmetic consumes on the following edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= '1;
      press  <= '0;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
          press[i]  <= ~sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // Saturating shadow duty. Limits are tested before adding/subtracting so
  // the value never overflows CW bits or underflows below zero. A press on
  // both buttons of a channel in the same clock cancels out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (press[i] && !press[CH+i]) begin
          shadow[i] <= (shadow[i] > INC_LIM) ? P_VAL : shadow[i] + STEP_V;
        end else if (press[CH+i] && !press[i]) begin
          shadow[i] <= (shadow[i] < STEP_V) ? '0 : shadow[i] - STEP_V;
        end
      end
    end
  end

`ifdef PWM_CENTER_ALIGN_EN
  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;

  dir_t dir;
  dir_t dir_next;

  // Up 0..PERIOD-1, then down PERIOD-2..1; reaching 0 always turns the
  // direction back to up, so a period start is simply cnt_next==0.
  always_comb begin
    cnt_next = cnt;
    dir_next = dir;
    if (dir == DIR_UP) begin
      if (cnt == P_LAST) begin
        cnt_next = P_LAST - CW'(1);
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end else begin
      cnt_next = cnt - CW'(1);
    end
    if (cnt_next == '0) begin
      dir_next = DIR_UP;
    end else if (dir == DIR_UP && cnt == P_LAST) begin
      dir_next = DIR_DOWN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir <= DIR_UP;
    end else begin
      dir <= dir_next;
    end
  end
`else
  // Edge-aligned counter: 0..PERIOD-1 then back to 0.
  always_comb begin
    cnt_next = (cnt == P_LAST) ? '0 : cnt + CW'(1);
  end
`endif

  // Outputs are computed from the next counter value and next active duty
  // so the registered pwm/wrap line up with cnt without a cycle of skew.
  // In center mode the high window sits around the turning point
  // (cnt >= PERIOD-duty), which keeps it symmetric about cnt=PERIOD-1.
  always_comb begin
    load        = (cnt_next == '0);
    active_next = active;
    pwm_next    = '0;
    for (int i = 0; i < CH; i++) begin
      if (load) begin
        active_next[i] = shadow[i];
      end
`ifdef PWM_CENTER_ALIGN_EN
      pwm_next[i] = (cnt_next >= (P_VAL - active_next[i]));
`else
      pwm_next[i] = (cnt_next < active_next[i]);
`endif
    end
  end

  // Counter, active duty and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      wrap   <= 1'b0;
      active <= '0;
      pwm    <= '0;
    end else begin
      cnt    <= cnt_next;
      wrap   <= load;
      active <= active_next;
      pwm    <= pwm_next;
    end
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// tb_pwm_multi_gen
//
// Directed bench for pwm_multi_gen with CH=4, CW=8, PERIOD=50, STEP=5,
// DB_CYCLES=4. Inputs are driven and outputs sampled 1 time unit after the
// rising clock edge. Defining PWM_CENTER_ALIGN_EN selects the center-aligned
// checks instead of the edge-aligned ones.

module tb_pwm_multi_gen;

  localparam int CH        = 4;
  localparam int CW        = 8;
  localparam int PERIOD    = 50;
  localparam int STEP      = 5;
  localparam int DB_CYCLES = 4;
`ifdef PWM_CENTER_ALIGN_EN
  localparam int PLEN = 2 * PERIOD - 2;
`else
  localparam int PLEN = PERIOD;
`endif

  logic             clk;
  logic             reset;
  logic [CH-1:0]    inc_n;
  logic [CH-1:0]    dec_n;
  logic [CH-1:0]    pwm;
  logic [CW-1:0]    cnt;
  logic             wrap;
  logic [CH*CW-1:0] duty_dbg;

  int checks   = 0;
  int failures = 0;
  int hiCount[CH];

  pwm_multi_gen #(
    .CH(CH), .CW(CW), .PERIOD(PERIOD), .STEP(STEP), .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inc_n(inc_n),
    .dec_n(dec_n),
    .pwm(pwm),
    .cnt(cnt),
    .wrap(wrap),
    .duty_dbg(duty_dbg)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold the masked buttons low for 'hold' clocks, then release and idle.
  task automatic applyStimulus(input logic [CH-1:0] incMask,
                               input logic [CH-1:0] decMask,
                               input int hold, input int gap);
    inc_n = ~incMask;
    dec_n = ~decMask;
    step(hold);
    inc_n = '1;
    dec_n = '1;
    step(gap);
  endtask

  // Return at a sample where wrap is high (possibly the current one).
  task automatic waitWrap();
    int k;
    k = 0;
    while (!wrap && k < 3 * PLEN) begin
      step(1);
      k++;
    end
    if (!wrap) checkOutput("wrap_timeout", 32'(wrap), 32'd1);
  endtask

  // Count high cycles per channel over one full period from a wrap.
  task automatic measurePeriod();
    waitWrap();
    for (int c = 0; c < CH; c++) hiCount[c] = 0;
    for (int k = 0; k < PLEN; k++) begin
      for (int c = 0; c < CH; c++) hiCount[c] += int'(pwm[c]);
      step(1);
    end
  endtask

  initial begin
    int gap;
    int maxCnt;
    int hi;
    logic [CW-1:0] midDuty;

    reset = 1'b0;
    inc_n = '1;
    dec_n = '1;
    step(3);

    // Reset state.
    checkOutput("rst_pwm",  32'(pwm),      32'd0);
    checkOutput("rst_cnt",  32'(cnt),      32'd0);
    checkOutput("rst_wrap", 32'(wrap),     32'd0);
    checkOutput("rst_duty", 32'(duty_dbg), 32'd0);

    reset = 1'b1;
    step(1);
    checkOutput("rel_cnt1", 32'(cnt), 32'd1);
    checkOutput("rel_wrap", 32'(wrap), 32'd0);

`ifdef PWM_CENTER_ALIGN_EN
    // Center-aligned: duty 10 -> 19 high cycles centred on cnt=49.
    applyStimulus(4'b0001, 4'b0000, 10, 10);
    applyStimulus(4'b0001, 4'b0000, 10, 10);
    checkOutput("ca_shadow", 32'(dut.shadow[0]), 32'd10);
    waitWrap();
    begin
      int firstHi;
      int lastHi;
      int wraps;
      firstHi = -1;
      lastHi  = -1;
      hi      = 0;
      wraps   = 0;
      maxCnt  = 0;
      for (int k = 0; k < PLEN; k++) begin
        if (k > 0 && wrap) wraps++;
        if (int'(cnt) > maxCnt) maxCnt = int'(cnt);
        if (pwm[0]) begin
          hi++;
          if (firstHi < 0) firstHi = int'(cnt);
          lastHi = int'(cnt);
        end
        step(1);
      end
      checkOutput("ca_hi",      32'(hi),      32'd19);
      checkOutput("ca_first",   32'(firstHi), 32'd40);
      checkOutput("ca_last",    32'(lastHi),  32'd40);
      checkOutput("ca_maxcnt",  32'(maxCnt),  32'd49);
      checkOutput("ca_nowrap",  32'(wraps),   32'd0);
      checkOutput("ca_period",  32'(wrap),    32'd1);
      checkOutput("ca_cnt0",    32'(cnt),     32'd0);
    end
`else
    // Wrap cadence: first wrap 50 edges after release, then every 50.
    gap = 1;
    while (!wrap && gap < 200) begin
      step(1);
      gap++;
    end
    checkOutput("first_wrap_gap", 32'(gap), 32'd50);
    checkOutput("wrap_cnt0", 32'(cnt), 32'd0);
    gap    = 0;
    maxCnt = 0;
    do begin
      step(1);
      gap++;
      if (int'(cnt) > maxCnt) maxCnt = int'(cnt);
    end while (!wrap && gap < 200);
    checkOutput("wrap_gap", 32'(gap), 32'd50);
    checkOutput("cnt_max", 32'(maxCnt), 32'd49);

    // Single press on inc_n[1]: shadow changes on edge 7 after the fall.
    inc_n[1] = 1'b0;
    step(6);
    checkOutput("press_edge6", 32'(dut.shadow[1]), 32'd0);
    step(1);
    checkOutput("press_edge7", 32'(dut.shadow[1]), 32'd5);
    step(3);
    inc_n[1] = 1'b1;
    step(10);
    measurePeriod();
    checkOutput("single_ch0", 32'(hiCount[0]), 32'd0);
    checkOutput("single_ch1", 32'(hiCount[1]), 32'd5);
    checkOutput("single_ch2", 32'(hiCount[2]), 32'd0);
    checkOutput("single_ch3", 32'(hiCount[3]), 32'd0);
    checkOutput("single_dbg", 32'(duty_dbg), 32'h0000_0500);

    // Saturation at PERIOD, then at zero.
    for (int p = 0; p < 12; p++) applyStimulus(4'b0001, 4'b0000, 6, 10);
    checkOutput("sat_hi_shadow", 32'(dut.shadow[0]), 32'd50);
    measurePeriod();
    checkOutput("sat_hi_pwm", 32'(hiCount[0]), 32'd50);
    checkOutput("sat_hi_dbg", 32'(duty_dbg[7:0]), 32'd50);
    checkOutput("sat_hi_ch1", 32'(hiCount[1]), 32'd5);
    for (int p = 0; p < 11; p++) applyStimulus(4'b0000, 4'b0001, 6, 10);
    checkOutput("sat_lo_shadow", 32'(dut.shadow[0]), 32'd0);
    measurePeriod();
    checkOutput("sat_lo_pwm", 32'(hiCount[0]), 32'd0);
    checkOutput("sat_lo_dbg", 32'(duty_dbg[7:0]), 32'd0);

    // Debounce: 3-clock low pulses are rejected, a longer hold steps once.
    for (int p = 0; p < 4; p++) begin
      inc_n[2] = 1'b0;
      step(3);
      inc_n[2] = 1'b1;
      step(3);
    end
    step(10);
    checkOutput("bounce_reject", 32'(dut.shadow[2]), 32'd0);
    applyStimulus(4'b0100, 4'b0000, 6, 10);
    checkOutput("bounce_accept", 32'(dut.shadow[2]), 32'd5);

    // Simultaneous inc and dec on one channel cancel.
    applyStimulus(4'b1000, 4'b0000, 10, 10);
    checkOutput("sim_pre", 32'(dut.shadow[3]), 32'd5);
    applyStimulus(4'b1000, 4'b1000, 10, 10);
    checkOutput("sim_both", 32'(dut.shadow[3]), 32'd5);

    // Mid-period shadow change on ch1 (5 -> 10) does not alter this period.
    waitWrap();
    hi      = 0;
    midDuty = '0;
    for (int k = 0; k < PLEN; k++) begin
      hi += int'(pwm[1]);
      if (k == 30) midDuty = duty_dbg[15:8];
      inc_n[1] = (k >= 5 && k < 15) ? 1'b0 : 1'b1;
      step(1);
    end
    inc_n = '1;
    checkOutput("mid_width_old", 32'(hi), 32'd5);
    checkOutput("mid_active_old", 32'(midDuty), 32'd5);
    checkOutput("mid_shadow_new", 32'(dut.shadow[1]), 32'd10);
    measurePeriod();
    checkOutput("mid_width_new", 32'(hiCount[1]), 32'd10);
    checkOutput("mid_ch2", 32'(hiCount[2]), 32'd5);
    checkOutput("mid_ch3", 32'(hiCount[3]), 32'd5);

    // Reset mid-period forces outputs low at once.
    waitWrap();
    step(3);
    checkOutput("pre_rst_cnt", 32'(cnt), 32'd3);
    checkOutput("pre_rst_pwm", 32'(pwm), 32'b1110);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_pwm",  32'(pwm),      32'd0);
    checkOutput("mid_rst_cnt",  32'(cnt),      32'd0);
    checkOutput("mid_rst_wrap", 32'(wrap),     32'd0);
    checkOutput("mid_rst_duty", 32'(duty_dbg), 32'd0);
    step(2);
    reset = 1'b1;
    step(1);
    checkOutput("mid_rel_cnt1", 32'(cnt), 32'd1);
    checkOutput("mid_rel_shadow", 32'(dut.shadow[1]), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
